plot_sequencer: RTL
===================

// Module: plot_sequencer
// PURPOSE
//  Top-level controller that draws one function plot. On redraw it clears the framebuffer,
//  runs the infix->RPN parser once, then sweeps every screen column. Per column it starts
//  the RPN evaluator with that column's fixed-point x and maps the y result to a row.
//  In-range rows are written to the framebuffer pixel port. Sits between UI/keyboard and parser/evaluator/framebuffer.
// PARAMETERS
//  INTEGER_PART_WIDTH     8    integer bits of signed fixed-point number
//  FRACTIONAL_PART_WIDTH  8    fractional bits of fixed-point number
//  SCREEN_WIDTH           640  columns swept
//  SCREEN_HEIGHT          480  rows; origin at (SCREEN_WIDTH/2, SCREEN_HEIGHT/2)
//  PIXELS_PER_UNIT_LOG2   4    pixels per unit = 2**P; must be <= FRACTIONAL_PART_WIDTH
// PORTS
//  clk           in   1                  system clock, all logic on posedge
//  rst           in   1                  asynchronous, active-high reset
//  redraw_req    in   1                  1-cycle request to (re)draw plot
//  busy          out  1                  high from accept of redraw until done
//  done          out  1                  1-cycle pulse when sweep finished
//  clear_start   out  1                  1-cycle pulse: framebuffer clear
//  clear_done    in   1                  1-cycle pulse: clear finished
//  parser_start  out  1                  1-cycle pulse to parser
//  parser_ready  in   1                  parser idle (drops 1 cycle after start)
//  eval_start    out  1                  1-cycle pulse to evaluator
//  eval_x        out  NW                 signed x operand, stable from eval_start to eval_valid
//  eval_valid    in   1                  1-cycle pulse: eval_result/eval_error valid
//  eval_result   in   NW                 signed fixed-point y
//  eval_error    in   1                  y undefined (div by 0, overflow)
//  pixel_valid   out  1                  pixel write request; held until pixel_ready
//  pixel_ready   in   1                  framebuffer accepts when valid&&ready
//  pixel_x       out  clog2(SCREEN_WIDTH)  column
//  pixel_y       out  clog2(SCREEN_HEIGHT) row
//  (NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH)
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-sweep): state IDLE, all outputs 0, column 0, pending 0.
//  - States: IDLE -> CLEAR -> CLEAR_WAIT -> PARSE -> PARSE_LEAVE -> PARSE_WAIT -> EVAL
//    -> EVAL_WAIT -> MAP -> PLOT -> NEXT_COL -> (EVAL | FINISH) -> IDLE.
//  - IDLE: redraw_req -> CLEAR, busy=1 next cycle. CLEAR: clear_start=1 one cycle.
//    CLEAR_WAIT: hold until clear_done.
//  - PARSE: parser_start=1 one cycle. PARSE_LEAVE: wait parser_ready==0. PARSE_WAIT: wait
//    parser_ready==1. The controller never treats the stale ready from before the start as completion.
//  - EVAL: eval_x = (col - SCREEN_WIDTH/2) <<< (FRACTIONAL_PART_WIDTH-PIXELS_PER_UNIT_LOG2),
//    signed, truncated to NW. eval_start=1 one cycle. EVAL_WAIT: wait eval_valid, register result+error.
//  - MAP: row = SCREEN_HEIGHT/2 - (y >>> (FRACTIONAL_PART_WIDTH-PIXELS_PER_UNIT_LOG2)),
//    computed in NW+2 signed bits. Plot iff !error && 0 <= row < SCREEN_HEIGHT, else skip to NEXT_COL.
//  - PLOT: pixel_valid=1 with pixel_x=col, pixel_y=row held stable; leave on valid&&ready.
//    pixel_valid drops the cycle after acceptance.
//  - NEXT_COL: col==SCREEN_WIDTH-1 -> FINISH, else col+1 -> EVAL.
//    FINISH: done=1 one cycle, busy=0 in IDLE.
//  - redraw_req while busy: set pending flag (multiple requests collapse to one). FINISH with
//    pending -> clear flag, go CLEAR directly (busy stays 1, done still pulses).
//  - redraw_req coincident with FINISH is latched as pending.
//  - Unexpected clear_done/eval_valid outside their wait states are ignored.
//  - No timeouts: the sequence relies on parser and evaluator always completing.
// STRUCTURE
//  - plotter_pkg: NUMBER_WIDTH, fixed-point widths, screen size, PIXELS_PER_UNIT_LOG2,
//    state encoding, shared with parser/evaluator/framebuffer.
//  - Sub-module plot_coord_map (combinational): col->eval_x, y->row+in_range; unit-testable alone.
//  - FSM, column counter, pending flag and result registers live in plot_sequencer.
// TESTING (bench: SCREEN_WIDTH=8, SCREEN_HEIGHT=8, PIXELS_PER_UNIT_LOG2=0, frac=8)
//  1 Evaluator model y=x, redraw_req -> clear, parse once, eval_x=-4..3 (0xFC00..0x0300);
//    pixels (1,7),(2,6)..(7,1) written, col 0 (row 8) skipped, one done pulse.
//  2 Model y=0 with pixel_ready low 5 cycles per pixel -> pixel_valid/x/y held stable;
//    8 pixels at row 4.
//  3 Model returns eval_error on col 4, else y=0 -> 7 pixels, none at x=4.
//  4 Parser ready drops 3 cycles late after start -> no eval_start before ready falls
//    then rises again.
//  5 redraw_req twice mid-sweep -> exactly one extra full sweep, two done pulses, busy continuous.
//  6 Assert rst during PLOT -> all outputs 0 same cycle; next redraw_req restarts from clear_start.

Source files
------------

// File: rtl/plotter_pkg.sv
// Shared constants for the function plotter: fixed-point number format, screen
// geometry, plot scale and the sequencer state encoding. Used by the sequencer,
// coordinate mapper, parser, evaluator and framebuffer.
package plotter_pkg;

  // Signed fixed-point number format
  localparam int unsigned DFLT_INTEGER_PART_WIDTH    = 8;
  localparam int unsigned DFLT_FRACTIONAL_PART_WIDTH = 8;
  localparam int unsigned NUMBER_WIDTH =
    DFLT_INTEGER_PART_WIDTH + DFLT_FRACTIONAL_PART_WIDTH;

  // Screen geometry; plot origin sits at the screen centre
  localparam int unsigned DFLT_SCREEN_WIDTH  = 640;
  localparam int unsigned DFLT_SCREEN_HEIGHT = 480;

  // Scale: 2**DFLT_PIXELS_PER_UNIT_LOG2 pixels per unit, at most one per LSB
  localparam int unsigned DFLT_PIXELS_PER_UNIT_LOG2 = 4;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_CLEAR       = 4'd1,
    ST_CLEAR_WAIT  = 4'd2,
    ST_PARSE       = 4'd3,
    ST_PARSE_LEAVE = 4'd4,
    ST_PARSE_WAIT  = 4'd5,
    ST_EVAL        = 4'd6,
    ST_EVAL_WAIT   = 4'd7,
    ST_MAP         = 4'd8,
    ST_PLOT        = 4'd9,
    ST_NEXT_COL    = 4'd10,
    ST_FINISH      = 4'd11
  } plot_state_e;

endpackage

// File: rtl/plot_coord_map.sv
// Combinational screen <-> plot coordinate conversion.
//   col        in   screen column
//   y          in   signed fixed-point function value
//   x_c        out  signed fixed-point x for the column (origin at screen centre)
//   row_c      out  screen row for y (low bits of the wide result)
//   in_range_c out  row lies inside 0 .. SCREEN_HEIGHT-1
module plot_coord_map
  import plotter_pkg::*;
#(
  parameter int unsigned INTEGER_PART_WIDTH    = DFLT_INTEGER_PART_WIDTH,
  parameter int unsigned FRACTIONAL_PART_WIDTH = DFLT_FRACTIONAL_PART_WIDTH,
  parameter int unsigned SCREEN_WIDTH          = DFLT_SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT         = DFLT_SCREEN_HEIGHT,
  parameter int unsigned PIXELS_PER_UNIT_LOG2  = DFLT_PIXELS_PER_UNIT_LOG2,
  localparam int unsigned NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  localparam int unsigned XW = $clog2(SCREEN_WIDTH),
  localparam int unsigned YW = $clog2(SCREEN_HEIGHT)
) (
  input  logic [XW-1:0] col,
  input  logic [NW-1:0] y,
  output logic [NW-1:0] x_c,
  output logic [YW-1:0] row_c,
  output logic          in_range_c
);

  // One pixel step equals 2**SH fixed-point LSBs
  localparam int unsigned SH = FRACTIONAL_PART_WIDTH - PIXELS_PER_UNIT_LOG2;
  // Two guard bits so that H/2 - y cannot wrap for any y
  localparam int unsigned MW = NW + 2;

  // Column to x: centre-relative pixel offset scaled to fixed point
  logic signed [31:0] col_off;
  assign col_off = signed'(32'(col)) - signed'(32'(SCREEN_WIDTH / 2));
  assign x_c     = NW'(col_off <<< SH);

  // y to row: screen rows grow downward, so subtract from the centre row
  logic signed [MW-1:0] y_ext;
  logic signed [MW-1:0] half_h;
  logic signed [MW-1:0] height_s;
  logic signed [MW-1:0] row_w;

  assign y_ext      = {{2{y[NW-1]}}, y};
  assign half_h     = MW'(SCREEN_HEIGHT / 2);
  assign height_s   = MW'(SCREEN_HEIGHT);
  assign row_w      = half_h - (y_ext >>> SH);
  assign in_range_c = ~row_w[MW-1] & (row_w < height_s);
  assign row_c      = YW'(row_w);

endmodule

// File: rtl/plot_sequencer.sv
// Plot controller: on redraw clears the framebuffer, runs the parser once, then
// evaluates the expression for every screen column and writes in-range points.
//   clk, rst                    clock, asynchronous active-high reset
//   redraw_req                  request a (re)draw; extra requests while busy collapse to one
//   busy, done                  busy from accept to end of sweep; done pulses at end
//   clear_start / clear_done    framebuffer clear handshake
//   parser_start / parser_ready parser start pulse / idle level
//   eval_start, eval_x          evaluator start pulse and x operand
//   eval_valid/result/error     evaluator response
//   pixel_valid/ready/x/y       framebuffer pixel write (valid held until ready)
module plot_sequencer
  import plotter_pkg::*;
#(
  parameter int unsigned INTEGER_PART_WIDTH    = DFLT_INTEGER_PART_WIDTH,
  parameter int unsigned FRACTIONAL_PART_WIDTH = DFLT_FRACTIONAL_PART_WIDTH,
  parameter int unsigned SCREEN_WIDTH          = DFLT_SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT         = DFLT_SCREEN_HEIGHT,
  parameter int unsigned PIXELS_PER_UNIT_LOG2  = DFLT_PIXELS_PER_UNIT_LOG2,
  localparam int unsigned NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  localparam int unsigned XW = $clog2(SCREEN_WIDTH),
  localparam int unsigned YW = $clog2(SCREEN_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redraw_req,
  output logic          busy,
  output logic          done,
  output logic          clear_start,
  input  logic          clear_done,
  output logic          parser_start,
  input  logic          parser_ready,
  output logic          eval_start,
  output logic [NW-1:0] eval_x,
  input  logic          eval_valid,
  input  logic [NW-1:0] eval_result,
  input  logic          eval_error,
  output logic          pixel_valid,
  input  logic          pixel_ready,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y
);

  plot_state_e   state_q, state_d;
  logic [XW-1:0] col_q, col_d;
  logic          pending_q, pending_d;
  logic [NW-1:0] y_q, y_d;
  logic          err_q, err_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          clear_start_q, clear_start_d;
  logic          parser_start_q, parser_start_d;
  logic          eval_start_q, eval_start_d;
  logic [NW-1:0] eval_x_q, eval_x_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic [XW-1:0] pixel_x_q, pixel_x_d;
  logic [YW-1:0] pixel_y_q, pixel_y_d;

  logic [NW-1:0] map_x_c;
  logic [YW-1:0] map_row_c;
  logic          map_in_range_c;

  // x is computed for the column about to be evaluated; row from the captured y
  plot_coord_map #(
    .INTEGER_PART_WIDTH   (INTEGER_PART_WIDTH),
    .FRACTIONAL_PART_WIDTH(FRACTIONAL_PART_WIDTH),
    .SCREEN_WIDTH         (SCREEN_WIDTH),
    .SCREEN_HEIGHT        (SCREEN_HEIGHT),
    .PIXELS_PER_UNIT_LOG2 (PIXELS_PER_UNIT_LOG2)
  ) u_map (
    .col       (col_d),
    .y         (y_q),
    .x_c       (map_x_c),
    .row_c     (map_row_c),
    .in_range_c(map_in_range_c)
  );

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      col_q          <= '0;
      pending_q      <= 1'b0;
      y_q            <= '0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      clear_start_q  <= 1'b0;
      parser_start_q <= 1'b0;
      eval_start_q   <= 1'b0;
      eval_x_q       <= '0;
      pixel_valid_q  <= 1'b0;
      pixel_x_q      <= '0;
      pixel_y_q      <= '0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      pending_q      <= pending_d;
      y_q            <= y_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      clear_start_q  <= clear_start_d;
      parser_start_q <= parser_start_d;
      eval_start_q   <= eval_start_d;
      eval_x_q       <= eval_x_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_x_q      <= pixel_x_d;
      pixel_y_q      <= pixel_y_d;
    end
  end

  // Next state, column counter, pending flag and evaluator capture
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    pending_d = pending_q;
    y_d       = y_q;
    err_d     = err_q;

    // Requests arriving during a draw collapse into a single follow-up draw
    if (redraw_req && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (redraw_req || pending_q) begin
          state_d   = ST_CLEAR;
          pending_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        state_d = ST_CLEAR_WAIT;
        col_d   = '0;
      end
      ST_CLEAR_WAIT: begin
        if (clear_done) state_d = ST_PARSE;
      end
      ST_PARSE: begin
        state_d = ST_PARSE_LEAVE;
      end
      // Ready is still high from before the start; see it fall before trusting it
      ST_PARSE_LEAVE: begin
        if (!parser_ready) state_d = ST_PARSE_WAIT;
      end
      ST_PARSE_WAIT: begin
        if (parser_ready) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        state_d = ST_EVAL_WAIT;
      end
      ST_EVAL_WAIT: begin
        if (eval_valid) begin
          y_d     = eval_result;
          err_d   = eval_error;
          state_d = ST_MAP;
        end
      end
      ST_MAP: begin
        state_d = (!err_q && map_in_range_c) ? ST_PLOT : ST_NEXT_COL;
      end
      ST_PLOT: begin
        if (pixel_valid_q && pixel_ready) state_d = ST_NEXT_COL;
      end
      ST_NEXT_COL: begin
        if (col_q == XW'(SCREEN_WIDTH - 1)) begin
          state_d = ST_FINISH;
        end else begin
          col_d   = col_q + XW'(1);
          state_d = ST_EVAL;
        end
      end
      // A request seen now or earlier restarts straight away, keeping busy high
      ST_FINISH: begin
        if (pending_q || redraw_req) begin
          state_d   = ST_CLEAR;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so the registered copies line up with state_q
  always_comb begin
    busy_d         = (state_d != ST_IDLE);
    done_d         = (state_d == ST_FINISH);
    clear_start_d  = (state_d == ST_CLEAR);
    parser_start_d = (state_d == ST_PARSE);
    eval_start_d   = (state_d == ST_EVAL);
    pixel_valid_d  = (state_d == ST_PLOT);
    eval_x_d       = eval_x_q;
    pixel_x_d      = pixel_x_q;
    pixel_y_d      = pixel_y_q;

    if (state_d == ST_EVAL) begin
      eval_x_d = map_x_c;
    end
    if ((state_q == ST_MAP) && (state_d == ST_PLOT)) begin
      pixel_x_d = col_q;
      pixel_y_d = map_row_c;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign clear_start  = clear_start_q;
  assign parser_start = parser_start_q;
  assign eval_start   = eval_start_q;
  assign eval_x       = eval_x_q;
  assign pixel_valid  = pixel_valid_q;
  assign pixel_x      = pixel_x_q;
  assign pixel_y      = pixel_y_q;

endmodule
